// File: rtl/nibble_serial_add_ctrl_if.sv
// Bundle between the nibble-serial add sequencer, its requester and the shared 4-bit adder.
// The optional ovf signal exists only when NIBBLE_SERIAL_OVF_EN is defined.
interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic         ovf;
`endif

  // The master side is the requester and also returns the adder's result.
  modport master (
`ifdef NIBBLE_SERIAL_OVF_EN
    input  ovf,
`endif
    output start, a, b, cin, add_sum, add_cout,
    input  busy, done, sum, cout, add_a, add_b, add_cin
  );

  modport slave (
`ifdef NIBBLE_SERIAL_OVF_EN
    output ovf,
`endif
    input  start, a, b, cin, add_sum, add_cout,
    output busy, done, sum, cout, add_a, add_b, add_cin
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Time-shares one external 4-bit adder to add two 4*NIBBLES-bit operands, LSB nibble first.
// Optional signed-overflow flag is enabled by defining NIBBLE_SERIAL_OVF_EN.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic          cout_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic          lastNibble;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic          ovf_q;
`endif

  assign idx_d      = idx_q + IW'(1);
  assign lastNibble = (idx_q == IW'(NIBBLES - 1));

  // The adder is driven only while running so it sees quiet zeros otherwise.
  assign bus.add_a   = (state_q == RUN) ? a_q[4*idx_q +: 4] : 4'd0;
  assign bus.add_b   = (state_q == RUN) ? b_q[4*idx_q +: 4] : 4'd0;
  assign bus.add_cin = (state_q == RUN) ? carry_q : 1'b0;

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef NIBBLE_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[4*idx_q +: 4] <= bus.add_sum;
          carry_q             <= bus.add_cout;
          idx_q               <= idx_d;
          // On the top nibble the adder's MSB is the result sign bit.
          if (lastNibble) begin
            cout_q  <= bus.add_cout;
`ifdef NIBBLE_SERIAL_OVF_EN
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (bus.add_sum[3] != a_q[W-1]);
`endif
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: table vectors, corner sequences and random ops
// checked against plain a+b+cin arithmetic; the shared adder is modelled combinationally.
module tb_nibble_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] expSum;
    logic         expCout;
    logic         expOvf;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Called just after a rising edge with the DUT idle; start is seen at the next edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic waitDone(input string tag, output int latency, output int busyCycles);
    latency    = 0;
    busyCycles = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput({tag, ".runSumCleared"}, 32'(bus.sum), 32'h0);
        checkOutput({tag, ".runCoutCleared"}, 32'(bus.cout), 32'h0);
      end
      if (bus.busy) busyCycles++;
      if (bus.done) begin
        latency = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W-1:0] expSum, input logic expCout, input logic expOvf);
    int lat;
    int bc;
    applyStimulus(a, b, cin);
    waitDone(tag, lat, bc);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(NIBBLES + 1));
    checkOutput({tag, ".busyCycles"}, 32'(bc), 32'(NIBBLES + 1));
    @(negedge clk);
    checkOutput({tag, ".doneLow"}, 32'(bus.done), 32'h0);
    checkOutput({tag, ".idleNotBusy"}, 32'(bus.busy), 32'h0);
    checkOutput({tag, ".sum"}, 32'(bus.sum), 32'(expSum));
    checkOutput({tag, ".cout"}, 32'(bus.cout), 32'(expCout));
`ifdef NIBBLE_SERIAL_OVF_EN
    checkOutput({tag, ".ovf"}, 32'(bus.ovf), 32'(expOvf));
`else
    if (expOvf === 1'bx) $display("[TB] note: undefined ovf expectation in %s", tag);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   full;
    int           doneCount;
    int           doneAt;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0003, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy", 32'(bus.busy), 32'h0);
    checkOutput("reset.done", 32'(bus.done), 32'h0);
    checkOutput("reset.sum", 32'(bus.sum), 32'h0);
    checkOutput("reset.cout", 32'(bus.cout), 32'h0);
    checkOutput("reset.addA", 32'(bus.add_a), 32'h0);
    checkOutput("reset.addCin", 32'(bus.add_cin), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++)
      runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].expSum, vecs[i].expCout, vecs[i].expOvf);

    // Carry ripple: add_cin must follow the carry chain nibble by nibble.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 1; i <= NIBBLES; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ripple.addCin%0d", i), 32'(bus.add_cin), (i > 1) ? 32'h1 : 32'h0);
      checkOutput($sformatf("ripple.addA%0d", i), 32'(bus.add_a), 32'hF);
      checkOutput($sformatf("ripple.addB%0d", i), 32'(bus.add_b), (i == 1) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("ripple.done", 32'(bus.done), 32'h1);
    checkOutput("ripple.sum", 32'(bus.sum), 32'h0);
    checkOutput("ripple.cout", 32'(bus.cout), 32'h1);
    checkOutput("ripple.doneAddA", 32'(bus.add_a), 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // A start pulse during RUN must be ignored.
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    doneCount = 0;
    doneAt    = 0;
    for (int c = 3; c <= 12; c++) begin
      @(negedge clk);
      if (bus.done) begin
        doneCount++;
        doneAt = c;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("ignore.doneCount", 32'(doneCount), 32'h1);
    checkOutput("ignore.doneAt", 32'(doneAt), 32'(NIBBLES + 1));
    checkOutput("ignore.sum", 32'(bus.sum), 32'h2345);
    checkOutput("ignore.cout", 32'(bus.cout), 32'h0);

    // Reset in the second RUN cycle aborts the operation with no done.
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort.busy", 32'(bus.busy), 32'h0);
    checkOutput("abort.done", 32'(bus.done), 32'h0);
    checkOutput("abort.sum", 32'(bus.sum), 32'h0);
    checkOutput("abort.cout", 32'(bus.cout), 32'h0);
    checkOutput("abort.addA", 32'(bus.add_a), 32'h0);
    checkOutput("abort.addB", 32'(bus.add_b), 32'h0);
    checkOutput("abort.addCin", 32'(bus.add_cin), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    doneCount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) doneCount++;
      @(posedge clk);
      #1;
    end
    checkOutput("abort.quietAfter", 32'(doneCount), 32'h0);
    runOp("afterAbort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Random operations against plain arithmetic.
    for (int i = 0; i < 40; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      runOp($sformatf("rand%0d", i), ra, rb, rc, full[W-1:0], full[W],
            (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
